// File: rtl/process_tx_word.sv
// rtl/process_tx_word.sv - USB transmit word serializer: NRZI, bit stuffing, abort, EOP
module process_tx_word #(
  parameter int          DATA_W       = 8,
  parameter int          STUFF_LIMIT  = 6,
  parameter int          EOP_SE0_BITS = 2,
  parameter int          NB_W         = $clog2(DATA_W/8) + 1,
  parameter logic [7:0]  DATA_START   = 8'h02,
  parameter logic [7:0]  DATA_STOP    = 8'h01
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [1:0]        JBit,
  input  logic [1:0]        KBit,
  input  logic [DATA_W-1:0] TxWordIn,
  input  logic [NB_W-1:0]   TxNumBytes,
  input  logic [7:0]        TxByteCtrlIn,
  input  logic              processTxWordWEn,
  output logic              processTxWordRdy,
  input  logic              TxAbort,
  output logic              USBWireReq,
  input  logic              USBWireGnt,
  input  logic              USBWireRdy,
  output logic              USBWireWEn,
  output logic [1:0]        USBWireData,
  output logic              USBWireCtrl
);

  localparam int              IDX_W     = NB_W + 3;
  localparam logic [NB_W-1:0] MAX_BYTES = NB_W'(DATA_W / 8);
  localparam logic            DRIVE     = 1'b1;
  localparam logic            TRI_STATE = 1'b0;
  localparam logic [1:0]      SE0       = 2'b00;

  typedef enum logic [3:0] {
    S_START, S_IDLE, S_WAIT_GNT, S_LOAD_BIT, S_WAIT_RDY, S_CHK,
    S_STUFF, S_STUFF_RDY, S_STUFF_CHK, S_STOP_CHK,
    S_ABORT_RDY, S_ABORT_CHK, S_EOP_RDY, S_EOP_CHK, S_FIN
  } state_t;

  state_t            r_state;
  logic [DATA_W-1:0] r_word;
  logic [NB_W-1:0]   r_nbytes;
  logic [7:0]        r_ctrl;
  logic [1:0]        r_line;
  logic [3:0]        r_ones;
  logic [IDX_W-1:0]  r_idx;
  logic [3:0]        r_cnt;
  logic              r_rdy;
  logic              r_req;
  logic              r_wen;
  logic [1:0]        r_data;
  logic              r_wctrl;

  logic [1:0]        w_toggled;
  logic              w_more;
  logic [NB_W-1:0]   w_nbytes;

  assign w_toggled = (r_line == JBit) ? KBit : JBit;
  assign w_more    = r_idx < {r_nbytes, 3'b000};
  assign w_nbytes  = (TxNumBytes == '0) ? MAX_BYTES : TxNumBytes;

  assign processTxWordRdy = r_rdy;
  assign USBWireReq       = r_req;
  assign USBWireWEn       = r_wen;
  assign USBWireData      = r_data;
  assign USBWireCtrl      = r_wctrl;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_state  <= S_START;
      r_word   <= '0;
      r_nbytes <= '0;
      r_ctrl   <= '0;
      r_line   <= 2'b00;
      r_ones   <= '0;
      r_idx    <= '0;
      r_cnt    <= '0;
      r_rdy    <= 1'b0;
      r_req    <= 1'b0;
      r_wen    <= 1'b0;
      r_data   <= 2'b00;
      r_wctrl  <= TRI_STATE;
    end else begin
      r_wen <= 1'b0;
      case (r_state)
        S_START: begin
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
        S_IDLE: begin
          if (processTxWordWEn && r_rdy) begin
            r_word   <= TxWordIn;
            r_nbytes <= w_nbytes;
            r_ctrl   <= TxByteCtrlIn;
            r_idx    <= '0;
            r_rdy    <= 1'b0;
            if (TxByteCtrlIn == DATA_START) begin
              r_line  <= JBit;
              r_ones  <= '0;
              r_req   <= 1'b1;
              r_state <= S_WAIT_GNT;
            end else begin
              r_state <= S_LOAD_BIT;
            end
          end
        end
        S_WAIT_GNT: if (USBWireGnt) r_state <= S_LOAD_BIT;
        // NRZI: a zero is a line transition, a one holds the line
        S_LOAD_BIT: begin
          r_word <= r_word >> 1;
          r_idx  <= r_idx + IDX_W'(1);
          if (r_word[0]) begin
            r_ones <= r_ones + 4'd1;
          end else begin
            r_line <= w_toggled;
            r_ones <= '0;
          end
          r_state <= S_WAIT_RDY;
        end
        S_WAIT_RDY, S_STUFF_RDY, S_ABORT_RDY: begin
          if (USBWireRdy) begin
            r_wen   <= 1'b1;
            r_data  <= r_line;
            r_wctrl <= DRIVE;
            r_state <= (r_state == S_WAIT_RDY)  ? S_CHK :
                       (r_state == S_STUFF_RDY) ? S_STUFF_CHK : S_ABORT_CHK;
          end
        end
        S_CHK, S_STUFF_CHK: begin
          if (TxAbort) begin
            r_cnt   <= '0;
            r_state <= S_ABORT_RDY;
          end else if (r_state == S_CHK && r_ones == 4'(STUFF_LIMIT)) begin
            r_state <= S_STUFF;
          end else if (w_more) begin
            r_state <= S_LOAD_BIT;
          end else begin
            r_state <= S_STOP_CHK;
          end
        end
        S_STUFF: begin
          r_line  <= w_toggled;
          r_ones  <= '0;
          r_state <= S_STUFF_RDY;
        end
        S_STOP_CHK: begin
          if (r_ctrl == DATA_STOP) begin
            r_cnt   <= '0;
            r_state <= S_EOP_RDY;
          end else begin
            r_rdy   <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        // Abort holds the line for one bit past the stuff limit: a deliberate stuff violation
        S_ABORT_CHK: begin
          if (r_cnt == 4'(STUFF_LIMIT)) begin
            r_cnt   <= '0;
            r_state <= S_EOP_RDY;
          end else begin
            r_cnt   <= r_cnt + 4'd1;
            r_state <= S_ABORT_RDY;
          end
        end
        S_EOP_RDY: begin
          if (USBWireRdy) begin
            r_wen   <= 1'b1;
            r_data  <= (r_cnt < 4'(EOP_SE0_BITS)) ? SE0 : JBit;
            r_wctrl <= (r_cnt == 4'(EOP_SE0_BITS + 1)) ? TRI_STATE : DRIVE;
            r_state <= S_EOP_CHK;
          end
        end
        S_EOP_CHK: begin
          if (r_cnt == 4'(EOP_SE0_BITS + 1)) begin
            r_state <= S_FIN;
          end else begin
            r_cnt   <= r_cnt + 4'd1;
            r_state <= S_EOP_RDY;
          end
        end
        S_FIN: begin
          r_req   <= 1'b0;
          r_rdy   <= 1'b1;
          r_state <= S_IDLE;
        end
        default: r_state <= S_START;
      endcase
    end
  end

endmodule

// File: tb/tb_process_tx_word.sv
// tb/tb_process_tx_word.sv - self-checking bench for process_tx_word
module tb_process_tx_word;

  localparam int         DW   = 16;
  localparam int         NBW  = 2;
  localparam int         LIM  = 6;
  localparam int         SE0N = 2;
  localparam logic [7:0] C_START = 8'h02;
  localparam logic [7:0] C_STOP  = 8'h01;
  localparam logic [7:0] C_MID   = 8'h55;
  localparam logic [1:0] J = 2'b10;
  localparam logic [1:0] K = 2'b01;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic [1:0]    JBit = J, KBit = K;
  logic [DW-1:0] TxWordIn = '0;
  logic [NBW-1:0] TxNumBytes = '0;
  logic [7:0]    TxByteCtrlIn = '0;
  logic          processTxWordWEn = 1'b0;
  logic          processTxWordRdy;
  logic          TxAbort = 1'b0;
  logic          USBWireReq;
  logic          USBWireGnt = 1'b1;
  logic          USBWireRdy = 1'b1;
  logic          USBWireWEn;
  logic [1:0]    USBWireData;
  logic          USBWireCtrl;

  process_tx_word #(
    .DATA_W(DW), .STUFF_LIMIT(LIM), .EOP_SE0_BITS(SE0N), .NB_W(NBW),
    .DATA_START(C_START), .DATA_STOP(C_STOP)
  ) dut (
    .clk(clk), .rst(rst), .JBit(JBit), .KBit(KBit),
    .TxWordIn(TxWordIn), .TxNumBytes(TxNumBytes), .TxByteCtrlIn(TxByteCtrlIn),
    .processTxWordWEn(processTxWordWEn), .processTxWordRdy(processTxWordRdy),
    .TxAbort(TxAbort), .USBWireReq(USBWireReq), .USBWireGnt(USBWireGnt),
    .USBWireRdy(USBWireRdy), .USBWireWEn(USBWireWEn),
    .USBWireData(USBWireData), .USBWireCtrl(USBWireCtrl)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [15:0] w0, w1, w2;
    int n0, n1, n2;
    int nw;
    int ab;
    bit rr;
    int gd;
    int exp_n;
  } vec_t;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  logic [2:0] cap[$];
  int         stamp[$];
  logic [2:0] expq[$];
  int  abort_at = -1;
  bit  rand_rdy = 1'b0;
  logic prev_wen = 1'b0;
  vec_t vt[8];
  logic [1:0] hl[16];
  logic [2:0] hseq[20];

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] req);
    checks++;
    if (act !== req) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h", name, act, req);
    end
  endtask

  // Wire-side monitor: captures every bit write and paces USBWireRdy
  initial forever begin
    @(negedge clk);
    if (USBWireWEn === 1'b1) begin
      cap.push_back({USBWireData, USBWireCtrl});
      stamp.push_back(cyc);
      chk("wen_needs_wire_rdy", {31'd0, USBWireRdy}, 1);
      chk("wen_not_back_to_back", {31'd0, prev_wen}, 0);
      if (abort_at >= 0 && cap.size() == abort_at + 1) TxAbort = 1'b1;
    end
    prev_wen = USBWireWEn;
    USBWireRdy = rand_rdy ? 1'($urandom_range(0, 1)) : 1'b1;
  end

  // Reference: flatten bytes to a bit stream, insert stuff zeros, then NRZI-encode
  task automatic build_exp(input vec_t v);
    logic [15:0] wa[3];
    int na[3];
    logic bits[$];
    logic [1:0] line;
    int ones;
    wa[0] = v.w0; wa[1] = v.w1; wa[2] = v.w2;
    na[0] = v.n0; na[1] = v.n1; na[2] = v.n2;
    for (int k = 0; k < v.nw; k++) begin
      int nb;
      nb = (na[k] == 0) ? DW / 8 : na[k];
      for (int i = 0; i < 8 * nb; i++) bits.push_back(wa[k][i]);
    end
    expq.delete();
    line = J;
    ones = 0;
    foreach (bits[i]) begin
      if (bits[i]) ones++;
      else begin line = (line == J) ? K : J; ones = 0; end
      expq.push_back({line, 1'b1});
      if (ones == LIM) begin
        line = (line == J) ? K : J;
        ones = 0;
        expq.push_back({line, 1'b1});
      end
    end
    if (v.ab >= 0) begin
      while (expq.size() > v.ab + 1) void'(expq.pop_back());
      line = expq[expq.size() - 1][2:1];
      repeat (LIM + 1) expq.push_back({line, 1'b1});
    end
    repeat (SE0N) expq.push_back({2'b00, 1'b1});
    expq.push_back({J, 1'b1});
    expq.push_back({J, 1'b0});
  endtask

  task automatic send_word(input logic [15:0] w, input int n, input logic [7:0] c);
    int t;
    t = 0;
    @(negedge clk);
    while (processTxWordRdy !== 1'b1 && t < 3000) begin @(negedge clk); t++; end
    chk("rdy_before_word", {31'd0, processTxWordRdy}, 1);
    TxWordIn = w;
    TxNumBytes = NBW'(n);
    TxByteCtrlIn = c;
    processTxWordWEn = 1'b1;
    @(negedge clk);
    processTxWordWEn = 1'b0;
  endtask

  task automatic run_packet(input vec_t v);
    int t, bad;
    logic [15:0] w;
    int n;
    logic [7:0] c;
    cap.delete();
    stamp.delete();
    abort_at = v.ab;
    rand_rdy = v.rr;
    USBWireGnt = (v.gd == 0);
    for (int k = 0; k < v.nw; k++) begin
      w = (k == 0) ? v.w0 : (k == 1) ? v.w1 : v.w2;
      n = (k == 0) ? v.n0 : (k == 1) ? v.n1 : v.n2;
      c = (k == 0) ? C_START : (k == v.nw - 1) ? C_STOP : C_MID;
      send_word(w, n, c);
      if (k == 0 && v.gd > 0) begin
        repeat (v.gd) @(negedge clk);
        USBWireGnt = 1'b1;
      end
    end
    t = 0;
    @(negedge clk);
    while (!(processTxWordRdy === 1'b1 && USBWireReq === 1'b0) && t < 4000) begin
      @(negedge clk); t++;
    end
    chk("packet_end_rdy", {31'd0, processTxWordRdy}, 1);
    chk("packet_end_req_low", {31'd0, USBWireReq}, 0);
    abort_at = -1;
    TxAbort = 1'b0;
    rand_rdy = 1'b0;
    build_exp(v);
    chk("write_count", cap.size(), expq.size());
    if (v.exp_n > 0) chk("table_write_count", cap.size(), v.exp_n);
    bad = -1;
    for (int i = 0; i < cap.size() && i < expq.size(); i++)
      if (bad < 0 && cap[i] !== expq[i]) bad = i;
    checks++;
    if (bad >= 0) begin
      errors++;
      $display("FAIL line_sequence index=%0d actual=%0h required=%0h", bad, cap[bad], expq[bad]);
    end
  endtask

  initial begin
    vec_t rv;
    int t;
    vt[0] = '{16'h0080, 16'h0000, 16'h0000, 1, 1, 0, 2, -1, 1'b0, 0, 20};
    vt[1] = '{16'h0080, 16'h00FF, 16'h0000, 1, 1, 0, 2, -1, 1'b0, 0, 21};
    vt[2] = '{16'h0080, 16'h0000, 16'h0000, 1, 1, 0, 2, -1, 1'b1, 10, 20};
    vt[3] = '{16'h0000, 16'hFF00, 16'h0000, 0, 1, 0, 2, -1, 1'b0, 0, 28};
    vt[4] = '{16'hFFFF, 16'hFF01, 16'h0000, 2, 1, 0, 2, -1, 1'b0, 0, 30};
    vt[5] = '{16'h00FF, 16'h000F, 16'h0000, 1, 1, 1, 3, -1, 1'b0, 0, 30};
    vt[6] = '{16'h0000, 16'h0000, 16'h0000, 1, 0, 0, 1, 3, 1'b0, 0, 15};
    vt[7] = '{16'h0000, 16'h00FC, 16'h0000, 1, 1, 0, 2, -1, 1'b0, 0, 21};
    hl = '{K, J, K, J, K, J, K, K, J, K, J, K, J, K, J, K};
    for (int i = 0; i < 16; i++) hseq[i] = {hl[i], 1'b1};
    hseq[16] = 3'b001; hseq[17] = 3'b001; hseq[18] = {J, 1'b1}; hseq[19] = {J, 1'b0};

    repeat (3) @(negedge clk);
    chk("reset_rdy", {31'd0, processTxWordRdy}, 0);
    chk("reset_req", {31'd0, USBWireReq}, 0);
    chk("reset_wen", {31'd0, USBWireWEn}, 0);
    chk("reset_data", {30'd0, USBWireData}, 0);
    chk("reset_ctrl", {31'd0, USBWireCtrl}, 0);
    rst = 1'b1;
    @(negedge clk);
    chk("rdy_after_start", {31'd0, processTxWordRdy}, 1);

    for (int i = 0; i < 8; i++) begin
      run_packet(vt[i]);
      if (i == 0) begin
        for (int j = 0; j < 20; j++) chk("hand_sequence", {29'd0, cap[j]}, {29'd0, hseq[j]});
        chk("data_bit_period", stamp[1] - stamp[0], 3);
        chk("eop_bit_period", stamp[19] - stamp[18], 2);
      end
    end

    // Reset while the stuffed bit is being written
    cap.delete();
    send_word(16'h00FF, 1, C_START);
    t = 0;
    while (cap.size() < 7 && t < 300) begin @(negedge clk); #1; t++; end
    chk("stuff_bit_line", {29'd0, cap[6]}, {29'd0, K, 1'b1});
    chk("stuff_bit_wen", {31'd0, USBWireWEn}, 1);
    rst = 1'b0;
    #1;
    chk("async_rst_wen", {31'd0, USBWireWEn}, 0);
    chk("async_rst_req", {31'd0, USBWireReq}, 0);
    chk("async_rst_ctrl", {31'd0, USBWireCtrl}, 0);
    chk("async_rst_data", {30'd0, USBWireData}, 0);
    chk("async_rst_rdy", {31'd0, processTxWordRdy}, 0);
    @(negedge clk);
    rst = 1'b1;
    run_packet(vt[0]);

    for (int r = 0; r < 24; r++) begin
      rv.w0 = 16'($urandom); rv.w1 = 16'($urandom); rv.w2 = 16'($urandom);
      rv.n0 = $urandom_range(0, 2); rv.n1 = $urandom_range(0, 2); rv.n2 = $urandom_range(0, 2);
      rv.rr = 1'($urandom_range(0, 1));
      rv.gd = $urandom_range(0, 3);
      rv.exp_n = 0;
      if (r % 4 == 3) begin
        rv.nw = 1;
        rv.ab = $urandom_range(0, 7);
      end else begin
        rv.nw = $urandom_range(2, 3);
        rv.ab = -1;
      end
      run_packet(rv);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #900000;
    $display("FAIL watchdog_timeout actual=running required=finished");
    $fatal(1, "watchdog");
  end

endmodule
